// File: rtl/multicycle_ctrl_ws.sv
// multicycle_ctrl_ws: multicycle control FSM for the 16-opcode CPU, with memory wait
// states, a global Hold stall, an InstrDone retirement pulse and recovery to FETCH from
// any illegal state/opcode. Optional macro CTRL_FAULT_EN enables the Fault pulse and FaultCnt.
module multicycle_ctrl_ws #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Op,
  input  logic       LMC,
  input  logic       Perform,
  input  logic       Hold,
  output logic       PCW,
  output logic       Jump,
  output logic       MW,
  output logic       LM,
  output logic       IW,
  output logic       IorD,
  output logic       MSrc,
  output logic       RW,
  output logic       SrcB,
  output logic       FU,
  output logic       SPW,
  output logic       SPIorD,
  output logic [2:0] RWSrc,
  output logic [2:0] ALUOp,
  output logic [7:0] s,
  output logic       InstrDone,
  output logic       Fault,
  output logic [7:0] FaultCnt
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  localparam logic [7:0] ST_FETCH  = 8'h01;
  localparam logic [7:0] ST_DECODE = 8'h02;
  localparam logic [7:0] ST_LOADM  = 8'h04;
  localparam logic [7:0] ST_CALC   = 8'h08;
  localparam logic [7:0] ST_MWRITE = 8'h10;
  localparam logic [7:0] ST_COPY   = 8'h20;
  localparam logic [7:0] ST_JUMP   = 8'h40;
  localparam logic [7:0] ST_POP    = 8'h80;

  logic [7:0] r_s;
  logic [3:0] r_wc;
  logic       r_instr_done;

  logic [7:0] w_s_leg;
  logic [7:0] w_s_nxt;
  logic       w_op_ok;
  logic       w_fault;
  logic       w_advance;

  // Opcode classes
  logic w_op_alu, w_op_imm, w_op_sto, w_op_cp, w_op_jr, w_op_push, w_op_pop, w_op_j;
  assign w_op_alu  = (Op == 4'd0) | (Op == 4'd4) | (Op == 4'd5) |
                     (Op == 4'd8) | (Op == 4'd9) | (Op == 4'd12);
  assign w_op_imm  = (Op == 4'd1) | (Op == 4'd13);
  assign w_op_sto  = (Op == 4'd2);
  assign w_op_cp   = (Op == 4'd6);
  assign w_op_jr   = (Op == 4'd14);
  assign w_op_push = (Op == 4'd10);
  assign w_op_pop  = (Op == 4'd11);
  assign w_op_j    = (Op == 4'd15);

  // State decode
  logic w_st_fetch, w_st_decode, w_st_loadm, w_st_calc;
  logic w_st_mwrite, w_st_copy, w_st_jump, w_st_pop;
  assign w_st_fetch  = r_s[0];
  assign w_st_decode = r_s[1];
  assign w_st_loadm  = r_s[2];
  assign w_st_calc   = r_s[3];
  assign w_st_mwrite = r_s[4];
  assign w_st_copy   = r_s[5];
  assign w_st_jump   = r_s[6];
  assign w_st_pop    = r_s[7];

  // Memory states wait for the counter; all others finish in a single cycle
  logic w_mem_state, w_done, w_onehot, w_exec_state, w_nxt_mem;
  assign w_mem_state  = w_st_fetch | w_st_loadm | w_st_mwrite | w_st_pop;
  assign w_done       = ~w_mem_state | (r_wc == 4'd0);
  assign w_onehot     = (r_s != 8'h00) && ((r_s & (r_s - 8'd1)) == 8'h00);
  assign w_exec_state = |r_s[7:2];
  assign w_nxt_mem    = w_s_nxt[0] | w_s_nxt[2] | w_s_nxt[4] | w_s_nxt[7];

  // State register; reset lands in FETCH and beats Hold
  always_ff @(posedge CLK) begin
    if (RESET) r_s <= ST_FETCH;
    else       r_s <= w_s_nxt;
  end

  // Next-state: legal successor, per-state opcode legality, and fault override
  always_comb begin
    w_s_leg = ST_FETCH;
    w_op_ok = 1'b0;
    case (r_s)
      ST_FETCH: begin
        w_op_ok = 1'b1;
        w_s_leg = ST_DECODE;
      end
      ST_DECODE: begin
        w_op_ok = 1'b1;
        if (!Perform)       w_s_leg = ST_FETCH;
        else if (w_op_alu)  w_s_leg = LMC ? ST_LOADM : ST_CALC;
        else if (w_op_imm)  w_s_leg = ST_CALC;
        else if (w_op_sto)  w_s_leg = LMC ? ST_LOADM : ST_MWRITE;
        else if (w_op_cp)   w_s_leg = LMC ? ST_LOADM : ST_COPY;
        else if (w_op_jr)   w_s_leg = LMC ? ST_LOADM : ST_JUMP;
        else if (w_op_push) w_s_leg = ST_MWRITE;
        else if (w_op_pop)  w_s_leg = ST_POP;
        else if (w_op_j)    w_s_leg = ST_JUMP;
        else                w_s_leg = ST_FETCH;
      end
      ST_LOADM: begin
        w_op_ok = w_op_alu | w_op_sto | w_op_cp | w_op_jr;
        if (w_op_alu)      w_s_leg = ST_CALC;
        else if (w_op_sto) w_s_leg = ST_MWRITE;
        else if (w_op_cp)  w_s_leg = ST_COPY;
        else               w_s_leg = ST_JUMP;
      end
      ST_CALC:   w_op_ok = w_op_alu | w_op_imm;
      ST_MWRITE: w_op_ok = w_op_sto | w_op_push;
      ST_COPY:   w_op_ok = w_op_cp;
      ST_JUMP:   w_op_ok = w_op_jr | w_op_j;
      ST_POP:    w_op_ok = w_op_pop;
      default:   w_op_ok = 1'b0;
    endcase
    // Faults recover immediately, without waiting for the wait counter
    w_fault   = ~w_onehot | ~w_op_ok | (w_exec_state & ~Perform);
    w_advance = ~Hold & (w_fault | w_done);
    w_s_nxt   = r_s;
    if (w_advance) w_s_nxt = w_fault ? ST_FETCH : w_s_leg;
  end

  // Wait counter: reload on entry to a memory state, otherwise count down to zero
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wc <= LP_WAIT;
    end else if (!Hold) begin
      if (w_advance && w_nxt_mem) r_wc <= LP_WAIT;
      else if (r_wc != 4'd0)      r_wc <= r_wc - 4'd1;
    end
  end

  // Retirement pulse: first FETCH cycle after leaving any non-FETCH state
  always_ff @(posedge CLK) begin
    if (RESET) r_instr_done <= 1'b0;
    else       r_instr_done <= w_advance && (w_s_nxt == ST_FETCH) && (r_s != ST_FETCH);
  end

`ifdef CTRL_FAULT_EN
  logic       r_fault;
  logic [7:0] r_fault_cnt;

  // Fault pulse and saturating fault counter, one event per actual recovery
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fault     <= 1'b0;
      r_fault_cnt <= 8'h00;
    end else begin
      r_fault <= ~Hold & w_fault;
      if (~Hold && w_fault && (r_fault_cnt != 8'hFF)) r_fault_cnt <= r_fault_cnt + 8'd1;
    end
  end

  assign Fault    = r_fault;
  assign FaultCnt = r_fault_cnt;
`else
  assign Fault    = 1'b0;
  assign FaultCnt = 8'h00;
`endif

  assign s         = r_s;
  assign InstrDone = r_instr_done;

  // Datapath controls: enables gated by ~Hold, memory-state writes wait for done
  always_comb begin
    PCW    = ~Hold & ((w_st_fetch & w_done) | (w_st_decode & w_op_j) | w_st_jump);
    Jump   = w_st_jump;
    MW     = ~Hold & w_st_mwrite & w_done;
    IW     = ~Hold & w_st_decode;
    LM     = (w_st_decode & Op[1] & Op[0]) | w_st_loadm;
    IorD   = w_st_fetch | (w_st_decode & Op[2]);
    MSrc   = w_st_loadm | ~Op[3];
    RW     = ~Hold & ((w_st_decode & Op[1] & Op[0] & ~Op[3]) |
                      w_st_copy |
                      (w_st_jump & LMC & Op[0]) |
                      (w_st_calc & ~(Op[0] & Op[2] & ~Op[3])) |
                      (w_st_pop & w_done));
    RWSrc  = {w_st_decode, Op[0] & Op[2], ~w_st_calc};
    ALUOp  = {Op[3:2], Op[0]};
    SrcB   = (Op[3] == Op[2]) & Op[0];
    FU     = ~Hold & w_st_calc & (Op == 4'd5);
    SPW    = ~Hold & ((w_st_pop & w_done) | (w_st_decode & w_op_push));
    SPIorD = w_st_pop;
  end

endmodule

// File: tb/tb_multicycle_ctrl_ws.sv
// Scoreboard bench for multicycle_ctrl_ws: four instances (WAIT_CYCLES 0..3) share inputs;
// each directed sequence pushes per-cycle expected outputs for one instance, and a
// negedge monitor pops and compares them. Fault fields expected only with CTRL_FAULT_EN.
module tb_multicycle_ctrl_ws;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET = 1'b1;
  logic       Hold = 1'b0;
  logic       LMC = 1'b0;
  logic       Perform = 1'b1;
  logic [3:0] Op = 4'd0;

  logic       pcw_w [4];
  logic       jump_w [4];
  logic       mw_w [4];
  logic       lm_w [4];
  logic       iw_w [4];
  logic       iord_w [4];
  logic       msrc_w [4];
  logic       rw_w [4];
  logic       srcb_w [4];
  logic       fu_w [4];
  logic       spw_w [4];
  logic       spiord_w [4];
  logic [2:0] rwsrc_w [4];
  logic [2:0] aluop_w [4];
  logic [7:0] s_w [4];
  logic       idone_w [4];
  logic       fault_w [4];
  logic [7:0] fcnt_w [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    multicycle_ctrl_ws #(.WAIT_CYCLES(g)) u_dut (
      .CLK(CLK), .RESET(RESET), .Op(Op), .LMC(LMC), .Perform(Perform), .Hold(Hold),
      .PCW(pcw_w[g]), .Jump(jump_w[g]), .MW(mw_w[g]), .LM(lm_w[g]), .IW(iw_w[g]),
      .IorD(iord_w[g]), .MSrc(msrc_w[g]), .RW(rw_w[g]), .SrcB(srcb_w[g]), .FU(fu_w[g]),
      .SPW(spw_w[g]), .SPIorD(spiord_w[g]), .RWSrc(rwsrc_w[g]), .ALUOp(aluop_w[g]),
      .s(s_w[g]), .InstrDone(idone_w[g]), .Fault(fault_w[g]), .FaultCnt(fcnt_w[g])
    );
  end

  typedef struct {
    int         d;
    int         tid;
    int         cyc;
    logic [7:0] s;
    logic [7:0] ctl;   // {PCW, MW, RW, SPW, SPIorD, IW, FU, Jump}
    logic [3:0] sel;   // {LM, IorD, MSrc, SrcB}
    logic [2:0] rsrc;
    logic [2:0] alu;
    logic       id;
    logic       flt;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cur = 0;
  int   tid = 0;
  int   tcyc = 0;
  logic [7:0] fc_exp = 8'h00;

  task automatic cmp(input string nm, input int t, input int c,
                     input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL t%0d.c%0d %s: got %h want %h", t, c, nm, act, req);
    end
  endtask

  // Monitor: every cycle with an expectation pending, compare the selected instance
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      int   k;
      logic [7:0] a_ctl;
      logic [3:0] a_sel;
      logic       r_flt;
      logic [7:0] r_fc;
      e = sb.pop_front();
      k = e.d;
      a_ctl = {pcw_w[k], mw_w[k], rw_w[k], spw_w[k], spiord_w[k], iw_w[k], fu_w[k], jump_w[k]};
      a_sel = {lm_w[k], iord_w[k], msrc_w[k], srcb_w[k]};
`ifdef CTRL_FAULT_EN
      r_flt = e.flt;
      r_fc  = e.fc;
`else
      r_flt = 1'b0;
      r_fc  = 8'h00;
`endif
      cmp("s",         e.tid, e.cyc, s_w[k], e.s);
      cmp("ctl",       e.tid, e.cyc, a_ctl, e.ctl);
      cmp("sel",       e.tid, e.cyc, {4'h0, a_sel}, {4'h0, e.sel});
      cmp("RWSrc",     e.tid, e.cyc, {5'h0, rwsrc_w[k]}, {5'h0, e.rsrc});
      cmp("ALUOp",     e.tid, e.cyc, {5'h0, aluop_w[k]}, {5'h0, e.alu});
      cmp("InstrDone", e.tid, e.cyc, {7'h0, idone_w[k]}, {7'h0, e.id});
      cmp("Fault",     e.tid, e.cyc, {7'h0, fault_w[k]}, {7'h0, r_flt});
      cmp("FaultCnt",  e.tid, e.cyc, fcnt_w[k], r_fc);
    end
  end

  // Push the expectation for the current cycle, then move to the next cycle
  task automatic chk(input logic [7:0] es, input logic [7:0] ectl, input logic [3:0] esel,
                     input logic [2:0] ersrc, input logic [2:0] ealu, input logic eid,
                     input logic eflt);
    exp_t e;
    e.d = cur; e.tid = tid; e.cyc = tcyc;
    e.s = es; e.ctl = ectl; e.sel = esel; e.rsrc = ersrc; e.alu = ealu;
    e.id = eid; e.flt = eflt; e.fc = fc_exp;
    sb.push_back(e);
    tcyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input int t, input int d, input logic [3:0] op, input logic lmc);
    tid = t; tcyc = 0; cur = d;
    RESET = 1'b1; Hold = 1'b0; Perform = 1'b1; Op = op; LMC = lmc;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    fc_exp = 8'h00;
  endtask

  initial begin
    // T1: W=0 ADD reg, then Perform=0 in DECODE, LUI, J
    start(1, 0, 4'd0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    chk(8'h08, 8'b0010_0000, 4'b0010, 3'd0, 3'd0, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b0);
    Perform = 1'b0;
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    Perform = 1'b1;
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b0);
    Op = 4'd3;
    chk(8'h02, 8'b0010_0100, 4'b1011, 3'd5, 3'd1, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0111, 3'd1, 3'd1, 1'b1, 1'b0);
    Op = 4'd15;
    chk(8'h02, 8'b1000_0100, 4'b1101, 3'd7, 3'd7, 1'b0, 1'b0);
    chk(8'h40, 8'b1000_0001, 4'b0001, 3'd3, 3'd7, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0101, 3'd3, 3'd7, 1'b1, 1'b0);

    // T2: W=2 STO with LMC
    start(2, 2, 4'd2, 1'b1);
    repeat (2) chk(8'h01, 8'b0000_0000, 4'b0110, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    repeat (3) chk(8'h04, 8'b0000_0000, 4'b1010, 3'd1, 3'd0, 1'b0, 1'b0);
    repeat (2) chk(8'h10, 8'b0000_0000, 4'b0010, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h10, 8'b0100_0000, 4'b0010, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h01, 8'b0000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b0);

    // T3: W=1 POP
    start(3, 1, 4'd11, 1'b0);
    chk(8'h01, 8'b0000_0000, 4'b0100, 3'd1, 3'd5, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0100, 3'd1, 3'd5, 1'b0, 1'b0);
    chk(8'h02, 8'b0000_0100, 4'b1000, 3'd5, 3'd5, 1'b0, 1'b0);
    chk(8'h80, 8'b0000_1000, 4'b0000, 3'd1, 3'd5, 1'b0, 1'b0);
    chk(8'h80, 8'b0011_1000, 4'b0000, 3'd1, 3'd5, 1'b0, 1'b0);
    chk(8'h01, 8'b0000_0000, 4'b0100, 3'd1, 3'd5, 1'b1, 1'b0);

    // T4: W=0 ADD with Hold for 4 cycles in CALC, then CMP
    start(4, 0, 4'd0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    Hold = 1'b1;
    repeat (4) chk(8'h08, 8'b0000_0000, 4'b0010, 3'd0, 3'd0, 1'b0, 1'b0);
    Hold = 1'b0;
    chk(8'h08, 8'b0010_0000, 4'b0010, 3'd0, 3'd0, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b0);
    Op = 4'd5;
    chk(8'h02, 8'b0000_0100, 4'b0110, 3'd7, 3'd3, 1'b0, 1'b0);
    chk(8'h08, 8'b0000_0010, 4'b0010, 3'd2, 3'd3, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd3, 3'd3, 1'b1, 1'b0);

    // T5: W=0 faults: Perform=0 in LOADM, illegal opcode in CALC, Hold delaying recovery
    start(5, 0, 4'd0, 1'b1);
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b0, 1'b0);
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    Perform = 1'b0;
    chk(8'h04, 8'b0000_0000, 4'b1010, 3'd1, 3'd0, 1'b0, 1'b0);
    Perform = 1'b1; LMC = 1'b0; fc_exp = 8'd1;
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b1);
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    Op = 4'd2;
    chk(8'h08, 8'b0010_0000, 4'b0010, 3'd0, 3'd0, 1'b0, 1'b0);
    fc_exp = 8'd2;
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b1);
    Op = 4'd0; LMC = 1'b1;
    chk(8'h02, 8'b0000_0100, 4'b0010, 3'd5, 3'd0, 1'b0, 1'b0);
    Perform = 1'b0; Hold = 1'b1;
    repeat (2) chk(8'h04, 8'b0000_0000, 4'b1010, 3'd1, 3'd0, 1'b0, 1'b0);
    Hold = 1'b0;
    chk(8'h04, 8'b0000_0000, 4'b1010, 3'd1, 3'd0, 1'b0, 1'b0);
    Perform = 1'b1; fc_exp = 8'd3;
    chk(8'h01, 8'b1000_0000, 4'b0110, 3'd1, 3'd0, 1'b1, 1'b1);

    // T6: W=3 PUSH, RESET asserted in MWRITE, then a full PUSH
    start(6, 3, 4'd10, 1'b0);
    repeat (3) chk(8'h01, 8'b0000_0000, 4'b0100, 3'd1, 3'd4, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0100, 3'd1, 3'd4, 1'b0, 1'b0);
    chk(8'h02, 8'b0001_0100, 4'b0000, 3'd5, 3'd4, 1'b0, 1'b0);
    RESET = 1'b1;
    chk(8'h10, 8'b0000_0000, 4'b0000, 3'd1, 3'd4, 1'b0, 1'b0);
    RESET = 1'b0;
    repeat (3) chk(8'h01, 8'b0000_0000, 4'b0100, 3'd1, 3'd4, 1'b0, 1'b0);
    chk(8'h01, 8'b1000_0000, 4'b0100, 3'd1, 3'd4, 1'b0, 1'b0);
    chk(8'h02, 8'b0001_0100, 4'b0000, 3'd5, 3'd4, 1'b0, 1'b0);
    repeat (3) chk(8'h10, 8'b0000_0000, 4'b0000, 3'd1, 3'd4, 1'b0, 1'b0);
    chk(8'h10, 8'b0100_0000, 4'b0000, 3'd1, 3'd4, 1'b0, 1'b0);
    chk(8'h01, 8'b0000_0000, 4'b0100, 3'd1, 3'd4, 1'b1, 1'b0);

    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
